// File: rtl/char_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module   : char_tokenizer
//  Brief    : ASCII byte stream to {prefix, value, eol} tokens with a
//             show-ahead output FIFO. Optional signed values: TOKENIZER_NEG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module char_tokenizer #(
    parameter int VAL_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [7:0]       i_char,
    output logic             o_stall,
    input  logic             i_flush,
    output logic             o_tok_vld,
    output logic [7:0]       o_tok_prefix,
    output logic [VAL_W-1:0] o_tok_val,
    output logic             o_tok_eol,
    input  logic             i_tok_stall,
    output logic             o_error
);

    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       c_LF    = 8'h0A;
    localparam logic [7:0]       c_CR    = 8'h0D;
    localparam logic [7:0]       c_COMMA = 8'h2C;
    localparam logic [7:0]       c_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_DIGITS = 3'd2,
        ST_SIGN   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t           r_state;
    logic [7:0]       r_prefix;
    logic [VAL_W-1:0] r_acc;

    logic [7:0]       r_mem_pfx [FIFO_DEPTH];
    logic [VAL_W-1:0] r_mem_val [FIFO_DEPTH];
    logic             r_mem_eol [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic             w_full;
    logic             w_accept;
    logic             w_flush;
    logic             w_is_digit;
    logic             w_is_upper;
    logic             w_is_lf;
    logic             w_is_sep;
    logic             w_is_cr;
    logic [3:0]       w_digit;
    logic [VAL_W+3:0] w_ext;
    logic [VAL_W+3:0] w_next;
    logic             w_ovf;
    logic             w_push;
    logic             w_push_eol;
    logic [VAL_W-1:0] w_push_val;
    logic             w_pop;

    assign w_full     = (r_count == c_FULL);
    assign w_accept   = i_vld & ~w_full;
    // A flush coinciding with a byte is dropped; the byte wins.
    assign w_flush    = i_flush & ~i_vld & ~w_full;
    assign w_is_digit = (i_char >= 8'h30) && (i_char <= 8'h39);
    assign w_is_upper = (i_char >= 8'h41) && (i_char <= 8'h5A);
    assign w_is_lf    = (i_char == c_LF);
    assign w_is_sep   = (i_char == c_COMMA) || (i_char == c_SPACE);
    assign w_is_cr    = (i_char == c_CR);
    assign w_digit    = i_char[3:0];

    // acc*10 + digit, widened so any overflow lands in the top four bits.
    assign w_ext  = {4'b0000, r_acc};
    assign w_next = (w_ext << 3) + (w_ext << 1) + {{VAL_W{1'b0}}, w_digit};

`ifdef TOKENIZER_NEG_EN
    localparam logic [VAL_W+3:0] c_NEG_LIM = {4'b0000, 1'b1, {(VAL_W-1){1'b0}}};
    localparam logic [7:0]       c_MINUS   = 8'h2D;

    logic r_neg;
    logic w_is_minus;

    assign w_is_minus = (i_char == c_MINUS);
    assign w_ovf      = r_neg ? (w_next > c_NEG_LIM) : (|w_next[VAL_W+3:VAL_W]);
    assign w_push_val = r_neg ? ({VAL_W{1'b0}} - r_acc) : r_acc;
`else
    assign w_ovf      = |w_next[VAL_W+3:VAL_W];
    assign w_push_val = r_acc;
`endif

    always_comb begin
        w_push     = 1'b0;
        w_push_eol = 1'b0;
        if (r_state == ST_DIGITS) begin
            if (w_accept && (w_is_lf || w_is_sep)) begin
                w_push     = 1'b1;
                w_push_eol = w_is_lf;
            end else if (w_flush) begin
                w_push     = 1'b1;
                w_push_eol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_prefix <= 8'h00;
            r_acc    <= '0;
`ifdef TOKENIZER_NEG_EN
            r_neg    <= 1'b0;
`endif
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_upper) begin
                        r_state  <= ST_PREFIX;
                        r_prefix <= i_char;
`ifdef TOKENIZER_NEG_EN
                        r_neg    <= 1'b0;
`endif
                    end else if (w_is_digit) begin
                        r_state  <= ST_DIGITS;
                        r_prefix <= 8'h00;
                        r_acc    <= {{(VAL_W-4){1'b0}}, w_digit};
`ifdef TOKENIZER_NEG_EN
                        r_neg    <= 1'b0;
                    end else if (w_is_minus) begin
                        r_state  <= ST_SIGN;
                        r_prefix <= 8'h00;
                        r_neg    <= 1'b1;
`endif
                    end else if (!(w_is_lf || w_is_sep || w_is_cr)) begin
                        r_state <= ST_ERR;
                    end
                end
                ST_PREFIX: begin
                    if (w_is_digit) begin
                        r_state <= ST_DIGITS;
                        r_acc   <= {{(VAL_W-4){1'b0}}, w_digit};
`ifdef TOKENIZER_NEG_EN
                    end else if (w_is_minus) begin
                        r_state <= ST_SIGN;
                        r_neg   <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_ERR;
                    end
                end
`ifdef TOKENIZER_NEG_EN
                ST_SIGN: begin
                    if (w_is_digit) begin
                        r_state <= ST_DIGITS;
                        r_acc   <= {{(VAL_W-4){1'b0}}, w_digit};
                    end else begin
                        r_state <= ST_ERR;
                    end
                end
`endif
                ST_DIGITS: begin
                    if (w_is_digit) begin
                        if (w_ovf) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_acc <= w_next[VAL_W-1:0];
                        end
                    end else if (w_is_lf || w_is_sep) begin
                        r_state <= ST_IDLE;
                        r_acc   <= '0;
                    end else if (!w_is_cr) begin
                        r_state <= ST_ERR;
                    end
                end
                default: r_state <= ST_ERR;
            endcase
        end else if (w_flush) begin
            case (r_state)
                ST_DIGITS: begin
                    r_state <= ST_IDLE;
                    r_acc   <= '0;
                end
                ST_PREFIX: r_state <= ST_ERR;
                ST_SIGN:   r_state <= ST_ERR;
                default:   r_state <= r_state;
            endcase
        end
    end

    // Output token FIFO; storage needs no reset since r_count gates visibility.
    assign w_pop = (r_count != '0) & ~i_tok_stall;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pfx[r_wr_ptr] <= r_prefix;
            r_mem_val[r_wr_ptr] <= w_push_val;
            r_mem_eol[r_wr_ptr] <= w_push_eol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_stall      = w_full;
    assign o_error      = (r_state == ST_ERR);
    assign o_tok_vld    = (r_count != '0);
    assign o_tok_prefix = o_tok_vld ? r_mem_pfx[r_rd_ptr] : 8'h00;
    assign o_tok_val    = o_tok_vld ? r_mem_val[r_rd_ptr] : '0;
    assign o_tok_eol    = o_tok_vld ? r_mem_eol[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_char_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_tokenizer
//  Brief    : Directed table-driven bench for char_tokenizer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_char_tokenizer;

    typedef struct packed {
        logic [7:0]  p;
        logic [31:0] v;
        logic        e;
    } tok_t;

    typedef struct packed {
        logic [3:0]     ntok;
        logic           flush;
        logic           err;
        tok_t [3:0]     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld = 1'b0;
    logic [7:0]  i_char = 8'h00;
    logic        o_stall;
    logic        i_flush = 1'b0;
    logic        o_tok_vld;
    logic [7:0]  o_tok_prefix;
    logic [31:0] o_tok_val;
    logic        o_tok_eol;
    logic        i_tok_stall = 1'b0;
    logic        o_error;

    int   n_checks = 0;
    int   n_pass   = 0;
    tok_t q[$];
    vec_t vecs[$];
    string stims[$];

    char_tokenizer #(.VAL_W(32), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_vld        (i_vld),
        .i_char       (i_char),
        .o_stall      (o_stall),
        .i_flush      (i_flush),
        .o_tok_vld    (o_tok_vld),
        .o_tok_prefix (o_tok_prefix),
        .o_tok_val    (o_tok_val),
        .o_tok_eol    (o_tok_eol),
        .i_tok_stall  (i_tok_stall),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    // Collect every token that will be popped at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && o_tok_vld && !i_tok_stall) begin
            q.push_back({o_tok_prefix, o_tok_val, o_tok_eol});
        end
    end

    function automatic tok_t mk(input logic [7:0] p, input logic [31:0] v, input logic e);
        tok_t t;
        t.p = p;
        t.v = v;
        t.e = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_vld   = 1'b0;
        i_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n      = 0;
        i_vld  = 1'b1;
        i_char = b;
        forever begin
            @(negedge clk);
            if (!o_stall) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL send_timeout: byte %h still stalled after %0d cycles, required accept", b, n);
                break;
            end
        end
        i_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send_byte(s[k]);
    endtask

    task automatic pulse_flush();
        i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
    endtask

    task automatic wait_tokens(input int n);
        for (int c = 0; c < 60 && q.size() < n; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string s, input vec_t v);
        stims.push_back(s);
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        do_reset();
        i_tok_stall = 1'b0;
        q.delete();
        send_str(stims[i]);
        if (v.flush) pulse_flush();
        wait_tokens(int'(v.ntok));
        chk($sformatf("v%0d_count", i), 64'(q.size()), 64'(v.ntok));
        for (int j = 0; j < int'(v.ntok); j++) begin
            if (j < q.size()) chk($sformatf("v%0d_tok%0d", i, j), 64'(q[j]), 64'(v.exp[j]));
        end
        chk($sformatf("v%0d_error", i), 64'(o_error), 64'(v.err));
    endtask

    initial begin
        vec_t v;

        v = '0; v.ntok = 2;
        v.exp[0] = mk(8'h4C, 68, 1'b1); v.exp[1] = mk(8'h52, 48, 1'b1);
        add_vec("L68\nR48\n", v);

        v = '0; v.ntok = 3;
        v.exp[0] = mk(8'h00, 7, 1'b0); v.exp[1] = mk(8'h00, 8, 1'b0);
        v.exp[2] = mk(8'h00, 9, 1'b1);
        add_vec("\n\n7,8 9\n", v);

        v = '0; v.ntok = 1; v.err = 1'b1;
        v.exp[0] = mk(8'h00, 32'hFFFFFFFF, 1'b1);
        add_vec("4294967295\n4294967296\n5\n", v);

        v = '0; v.ntok = 1;
        v.exp[0] = mk(8'h41, 5, 1'b1);
        add_vec("A5\015\n", v);

        v = '0; v.err = 1'b1;
        add_vec("A,\n", v);

        v = '0; v.err = 1'b1;
        add_vec("12#3\n", v);

        v = '0; v.ntok = 1; v.flush = 1'b1;
        v.exp[0] = mk(8'h00, 12, 1'b1);
        add_vec("12", v);

        v = '0; v.flush = 1'b1; v.err = 1'b1;
        add_vec("Z", v);

`ifdef TOKENIZER_NEG_EN
        v = '0; v.ntok = 1;
        v.exp[0] = mk(8'h4C, 32'hFFFFFFF4, 1'b1);
        add_vec("L-12\n", v);

        v = '0; v.ntok = 2;
        v.exp[0] = mk(8'h00, 32'hFFFFFFF9, 1'b0); v.exp[1] = mk(8'h00, 3, 1'b1);
        add_vec("-7, 3\n", v);

        v = '0; v.ntok = 1;
        v.exp[0] = mk(8'h00, 32'h80000000, 1'b1);
        add_vec("-2147483648\n", v);

        v = '0; v.err = 1'b1;
        add_vec("-2147483649\n", v);
`else
        v = '0; v.err = 1'b1;
        add_vec("L-12\n", v);

        v = '0; v.err = 1'b1;
        add_vec("-7, 3\n", v);
`endif

        // Reset state
        do_reset();
        chk("rst_tok_vld", 64'(o_tok_vld), 64'd0);
        chk("rst_prefix",  64'(o_tok_prefix), 64'd0);
        chk("rst_val",     64'(o_tok_val), 64'd0);
        chk("rst_eol",     64'(o_tok_eol), 64'd0);
        chk("rst_stall",   64'(o_stall), 64'd0);
        chk("rst_error",   64'(o_error), 64'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Backpressure: ten tokens with the consumer stalled for a while
        do_reset();
        q.delete();
        i_tok_stall = 1'b1;
        for (int n = 0; n < 3; n++) send_str($sformatf("R%0d\n", n));
        chk("bp_stall_after3", 64'(o_stall), 64'd0);
        send_str("R3\n");
        chk("bp_stall_after4", 64'(o_stall), 64'd1);
        fork
            begin
                repeat (30) @(posedge clk);
                #1 i_tok_stall = 1'b0;
            end
            begin
                for (int n = 4; n < 10; n++) send_str($sformatf("R%0d\n", n));
            end
        join
        wait_tokens(10);
        chk("bp_count", 64'(q.size()), 64'd10);
        for (int n = 0; n < 10; n++) begin
            if (n < q.size()) chk($sformatf("bp_tok%0d", n), 64'(q[n]), 64'(mk(8'h52, 32'(n), 1'b1)));
        end
        chk("bp_error", 64'(o_error), 64'd0);

        // Flush terminates a token; reset mid-token discards everything
        do_reset();
        q.delete();
        i_tok_stall = 1'b1;
        send_str("R5");
        pulse_flush();
        chk("fl_tok_vld", 64'(o_tok_vld), 64'd1);
        chk("fl_head", 64'({o_tok_prefix, o_tok_val, o_tok_eol}), 64'(mk(8'h52, 5, 1'b1)));
        send_str("L3");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mr_tok_vld", 64'(o_tok_vld), 64'd0);
        chk("mr_val",     64'(o_tok_val), 64'd0);
        chk("mr_error",   64'(o_error), 64'd0);
        i_tok_stall = 1'b0;
        q.delete();
        send_str("9\n");
        wait_tokens(1);
        chk("mr_count", 64'(q.size()), 64'd1);
        if (q.size() > 0) chk("mr_tok", 64'(q[0]), 64'(mk(8'h00, 9, 1'b1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
